interrupt_sequencer: RTL and testbench

- Consumer side of the interrupt request flip-flops: takes pending `irq_generated` / `nmi_generated` levels and runs the 7-cycle interrupt entry sequence: dummy reads, push PCH, PCL and P, then fetch the vector.
- Returns a one-cycle acknowledge to the matching request FF.
- Sits in control_logic, between the request FFs and the bus/register-file mux controls.
- Also handles software BRK, so all vectored entries share one path.

---
 rtl/interrupt_sequencer_pkg.sv | 87 ++++++++
 rtl/interrupt_sequencer_priority_select.sv | 29 ++
 rtl/interrupt_sequencer.sv | 142 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: state and kind
// enums, mux-select encodings, default vectors and the per-state control table.
// Optional behaviour in the sequencer is controlled by macro NMI_HIJACK_EN.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_T1       = 3'd1,
        ST_T2       = 3'd2,
        ST_PUSH_PCH = 3'd3,
        ST_PUSH_PCL = 3'd4,
        ST_PUSH_P   = 3'd5,
        ST_VEC_LO   = 3'd6,
        ST_VEC_HI   = 3'd7
    } int_state_t;

    typedef enum logic [1:0] {
        KIND_IRQ = 2'd0,
        KIND_NMI = 2'd1,
        KIND_BRK = 2'd2
    } int_kind_t;

    // Address mux select
    localparam logic [1:0] ADDR_SEL_PC     = 2'd0;
    localparam logic [1:0] ADDR_SEL_STACK  = 2'd1;
    localparam logic [1:0] ADDR_SEL_VECTOR = 2'd2;

    // Data-out mux select
    localparam logic [1:0] DATA_SEL_PCH = 2'd0;
    localparam logic [1:0] DATA_SEL_PCL = 2'd1;
    localparam logic [1:0] DATA_SEL_P   = 2'd2;

    localparam logic [15:0] DEFAULT_NMI_VECTOR = 16'hFFFA;
    localparam logic [15:0] DEFAULT_IRQ_VECTOR = 16'hFFFE;

    // Controls that depend only on the state being occupied
    typedef struct packed {
        logic       busy;
        logic [1:0] addr_sel;
        logic [1:0] data_out_sel;
        logic       bus_write;
        logic       sp_dec;
        logic       load_pcl;
        logic       load_pch;
        logic       set_i_flag;
    } int_ctrl_t;

    function automatic int_ctrl_t state_ctrl(int_state_t s);
        int_ctrl_t c;
        c              = '0;
        c.addr_sel     = ADDR_SEL_PC;
        c.data_out_sel = DATA_SEL_PCH;
        c.busy         = (s != ST_IDLE);
        case (s)
            ST_PUSH_PCH: begin
                c.addr_sel     = ADDR_SEL_STACK;
                c.data_out_sel = DATA_SEL_PCH;
                c.bus_write    = 1'b1;
                c.sp_dec       = 1'b1;
            end
            ST_PUSH_PCL: begin
                c.addr_sel     = ADDR_SEL_STACK;
                c.data_out_sel = DATA_SEL_PCL;
                c.bus_write    = 1'b1;
                c.sp_dec       = 1'b1;
            end
            ST_PUSH_P: begin
                c.addr_sel     = ADDR_SEL_STACK;
                c.data_out_sel = DATA_SEL_P;
                c.bus_write    = 1'b1;
                c.sp_dec       = 1'b1;
                c.set_i_flag   = 1'b1;
            end
            ST_VEC_LO: begin
                c.addr_sel = ADDR_SEL_VECTOR;
                c.load_pcl = 1'b1;
            end
            ST_VEC_HI: begin
                c.addr_sel = ADDR_SEL_VECTOR;
                c.load_pch = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_priority_select.sv
// Combinational priority encoder for vectored entry sources:
// NMI beats IRQ beats BRK. valid is high when any source is present.
module int_priority_select
    import interrupt_sequencer_pkg::*;
(
    input  logic       nmi,
    input  logic       irq,
    input  logic       brk,
    output logic [1:0] kind,
    output logic       valid
);

    // Fixed-priority selection of the entry kind
    always_comb begin
        kind  = KIND_IRQ;
        valid = 1'b0;
        if (nmi) begin
            kind  = KIND_NMI;
            valid = 1'b1;
        end else if (irq) begin
            kind  = KIND_IRQ;
            valid = 1'b1;
        end else if (brk) begin
            kind  = KIND_BRK;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: runs the 7-cycle NMI/IRQ/BRK entry
// (two dummy reads, push PCH/PCL/P, fetch vector) and pulses the
// acknowledge back to the matching request flip-flop.
// Macro NMI_HIJACK_EN: when defined, an NMI arriving during T1..PUSH_PCL
// of an IRQ/BRK entry redirects the sequence to the NMI vector.
// RDY gates every strobe combinationally so a stalled cycle never writes,
// decrements SP, loads PC or sets I; state and selects simply hold.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] NMI_VECTOR = DEFAULT_NMI_VECTOR,
    parameter logic [15:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        instr_boundary,
    input  logic        ready,
    input  logic        irq_generated,
    input  logic        nmi_generated,
    input  logic        brk_start,
    output logic        irq_acknowledged,
    output logic        nmi_acknowledged,
    output logic        busy,
    output logic [1:0]  addr_sel,
    output logic [1:0]  data_out_sel,
    output logic        bus_write,
    output logic        sp_dec,
    output logic [15:0] vector_addr,
    output logic        load_pcl,
    output logic        load_pch,
    output logic        set_i_flag,
    output logic        push_b_flag
);

    int_state_t  state_reg;
    int_state_t  state_next;
    int_kind_t   kind_reg;
    int_kind_t   sel_kind;
    int_kind_t   eff_kind;
    logic [1:0]  sel_kind_bits;
    logic        sel_valid;
    logic        start;
    logic        hijack;
    logic        brk_reg;
    logic        push_b_reg;
    logic        irq_pend_reg;
    logic        nmi_pend_reg;
    int_ctrl_t   ctrl_reg;
    logic [15:0] vector_reg;
    logic [15:0] vector_next;

    int_priority_select u_priority (
        .nmi   (nmi_generated),
        .irq   (irq_generated),
        .brk   (brk_start),
        .kind  (sel_kind_bits),
        .valid (sel_valid)
    );

    assign sel_kind = int_kind_t'(sel_kind_bits);
    assign start    = (state_reg == ST_IDLE) && instr_boundary && sel_valid;

`ifdef NMI_HIJACK_EN
    // An NMI before the P push is committed takes over the running entry
    assign hijack = nmi_generated && (kind_reg != KIND_NMI) &&
                    (state_reg inside {ST_T1, ST_T2, ST_PUSH_PCH, ST_PUSH_PCL});
`else
    assign hijack = 1'b0;
`endif

    assign eff_kind = hijack ? KIND_NMI : kind_reg;

    // Next-state sequencing: fixed walk through the entry once started
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_T1;
            ST_T1:       state_next = ST_T2;
            ST_T2:       state_next = ST_PUSH_PCH;
            ST_PUSH_PCH: state_next = ST_PUSH_PCL;
            ST_PUSH_PCL: state_next = ST_PUSH_P;
            ST_PUSH_P:   state_next = ST_VEC_LO;
            ST_VEC_LO:   state_next = ST_VEC_HI;
            ST_VEC_HI:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Vector base is fixed on entry to PUSH_P, then stepped to the high byte
    always_comb begin
        vector_next = vector_reg;
        case (state_reg)
            ST_PUSH_PCL: vector_next = (eff_kind == KIND_NMI) ? NMI_VECTOR : IRQ_VECTOR;
            ST_VEC_LO:   vector_next = vector_reg + 16'd1;
            default:     ;
        endcase
    end

    // FSM state, latched kind and registered per-state controls
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= ST_IDLE;
            kind_reg     <= KIND_IRQ;
            brk_reg      <= 1'b0;
            push_b_reg   <= 1'b0;
            irq_pend_reg <= 1'b0;
            nmi_pend_reg <= 1'b0;
            ctrl_reg     <= state_ctrl(ST_IDLE);
            vector_reg   <= IRQ_VECTOR;
        end else if (ready) begin
            state_reg    <= state_next;
            ctrl_reg     <= state_ctrl(state_next);
            vector_reg   <= vector_next;
            push_b_reg   <= (state_next == ST_PUSH_P) && brk_reg;
            irq_pend_reg <= 1'b0;
            nmi_pend_reg <= hijack;
            if (start) begin
                kind_reg     <= sel_kind;
                brk_reg      <= (sel_kind == KIND_BRK);
                irq_pend_reg <= (sel_kind == KIND_IRQ);
                nmi_pend_reg <= (sel_kind == KIND_NMI);
            end else begin
                kind_reg <= eff_kind;
            end
        end
    end

    assign busy             = ctrl_reg.busy;
    assign addr_sel         = ctrl_reg.addr_sel;
    assign data_out_sel     = ctrl_reg.data_out_sel;
    assign bus_write        = ctrl_reg.bus_write  & ready;
    assign sp_dec           = ctrl_reg.sp_dec     & ready;
    assign load_pcl         = ctrl_reg.load_pcl   & ready;
    assign load_pch         = ctrl_reg.load_pch   & ready;
    assign set_i_flag       = ctrl_reg.set_i_flag & ready;
    assign push_b_flag      = push_b_reg;
    assign vector_addr      = vector_reg;
    // A pending ack waits for the first ready cycle and is then dropped
    assign irq_acknowledged = irq_pend_reg & ready;
    assign nmi_acknowledged = nmi_pend_reg & ready;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer. A step-counting reference
// model predicts every output each cycle; directed scenarios add explicit
// checks on counts, cycle positions and vector values.
`timescale 1ns/1ps
module tb_interrupt_sequencer;

    localparam logic [15:0] NMI_V = 16'hFFFA;
    localparam logic [15:0] IRQ_V = 16'hFFFE;
    localparam int K_IRQ = 0;
    localparam int K_NMI = 1;
    localparam int K_BRK = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        instr_boundary = 1'b0;
    logic        ready = 1'b1;
    logic        irq_generated = 1'b0;
    logic        nmi_generated = 1'b0;
    logic        brk_start = 1'b0;
    logic        irq_acknowledged, nmi_acknowledged, busy;
    logic [1:0]  addr_sel, data_out_sel;
    logic        bus_write, sp_dec, load_pcl, load_pch, set_i_flag, push_b_flag;
    logic [15:0] vector_addr;

    interrupt_sequencer dut (
        .clk              (clk),
        .nrst             (nrst),
        .instr_boundary   (instr_boundary),
        .ready            (ready),
        .irq_generated    (irq_generated),
        .nmi_generated    (nmi_generated),
        .brk_start        (brk_start),
        .irq_acknowledged (irq_acknowledged),
        .nmi_acknowledged (nmi_acknowledged),
        .busy             (busy),
        .addr_sel         (addr_sel),
        .data_out_sel     (data_out_sel),
        .bus_write        (bus_write),
        .sp_dec           (sp_dec),
        .vector_addr      (vector_addr),
        .load_pcl         (load_pcl),
        .load_pch         (load_pch),
        .set_i_flag       (set_i_flag),
        .push_b_flag      (push_b_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic [1:0]  addr_sel;
        logic [1:0]  data_out_sel;
        logic        bus_write;
        logic        sp_dec;
        logic        load_pcl;
        logic        load_pch;
        logic        set_i_flag;
        logic        push_b_flag;
        logic        irq_ack;
        logic        nmi_ack;
        logic [15:0] vector_addr;
    } outs_t;

    int errors = 0;
    int checks = 0;
    int seq_n  = 0;

    // Reference model: m_step counts active cycles of an entry (0 = idle, 1..7)
    int          m_step;
    int          m_kind;
    bit          m_brk;
    bit          m_irq_due;
    bit          m_nmi_due;
    logic [15:0] m_vec;

    task automatic model_reset();
        m_step = 0; m_kind = K_IRQ; m_brk = 0;
        m_irq_due = 0; m_nmi_due = 0; m_vec = IRQ_V;
    endtask

    // Advance the model across one rising edge using the inputs held this cycle
    task automatic model_step();
        if (ready) begin
            m_irq_due = 0;
            m_nmi_due = 0;
            if (m_step == 0) begin
                if (instr_boundary && (nmi_generated || irq_generated || brk_start)) begin
                    m_kind    = nmi_generated ? K_NMI : (irq_generated ? K_IRQ : K_BRK);
                    m_brk     = (m_kind == K_BRK);
                    m_irq_due = (m_kind == K_IRQ);
                    m_nmi_due = (m_kind == K_NMI);
                    m_step    = 1;
                    $display("seq %0d start kind=%s t=%0t", seq_n,
                             m_kind == K_NMI ? "NMI" : (m_kind == K_IRQ ? "IRQ" : "BRK"), $time);
                    seq_n++;
                end
            end else begin
`ifdef NMI_HIJACK_EN
                if (m_step >= 1 && m_step <= 4 && m_kind != K_NMI && nmi_generated) begin
                    m_kind    = K_NMI;
                    m_nmi_due = 1;
                end
`endif
                m_step++;
                if (m_step == 5)      m_vec = (m_kind == K_NMI) ? NMI_V : IRQ_V;
                else if (m_step == 7) m_vec = m_vec + 16'd1;
                else if (m_step == 8) m_step = 0;
            end
        end
    endtask

    function automatic outs_t model_out();
        outs_t o;
        o = '0;
        o.busy = (m_step != 0);
        if (m_step >= 3 && m_step <= 5) begin
            o.addr_sel     = 2'd1;
            o.data_out_sel = 2'(m_step - 3);
            o.bus_write    = ready;
            o.sp_dec       = ready;
        end else if (m_step >= 6) begin
            o.addr_sel = 2'd2;
        end
        o.set_i_flag  = ready && (m_step == 5);
        o.push_b_flag = (m_step == 5) && m_brk;
        o.load_pcl    = ready && (m_step == 6);
        o.load_pch    = ready && (m_step == 7);
        o.irq_ack     = ready && m_irq_due;
        o.nmi_ack     = ready && m_nmi_due;
        o.vector_addr = m_vec;
        return o;
    endfunction

    function automatic outs_t reset_outs();
        outs_t o;
        o = '0;
        o.vector_addr = IRQ_V;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.busy = busy; o.addr_sel = addr_sel; o.data_out_sel = data_out_sel;
        o.bus_write = bus_write; o.sp_dec = sp_dec; o.load_pcl = load_pcl;
        o.load_pch = load_pch; o.set_i_flag = set_i_flag; o.push_b_flag = push_b_flag;
        o.irq_ack = irq_acknowledged; o.nmi_ack = nmi_acknowledged;
        o.vector_addr = vector_addr;
        return o;
    endfunction

    // Called after a falling edge: cross the next rising edge, update the model,
    // and behave like the request FFs (clear on ack). Boundary/BRK are one-cycle.
    task automatic advance();
        logic ia, na;
        ia = irq_acknowledged;
        na = nmi_acknowledged;
        @(posedge clk);
        model_step();
        #1;
        if (ia) irq_generated = 1'b0;
        if (na) nmi_generated = 1'b0;
        instr_boundary = 1'b0;
        brk_start      = 1'b0;
    endtask

    task automatic test_reset();
        outs_t obs;
        nrst = 1'b1;
        #2 nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        obs = sample();
        checks++;
        if (obs !== reset_outs())
            begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, reset_outs()); end
        nrst = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        $display("test_reset done");
    endtask

    task automatic test_irq();
        outs_t exp, obs;
        int busy_n = 0, ack_n = 0;
        irq_generated = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL irq_cycle c=%0d got=%h exp=%h", c, obs, exp); end
            if (busy) busy_n++;
            if (irq_acknowledged) begin
                ack_n++; checks++;
                if (c != 1) begin errors++; $display("FAIL irq_ack_pos c=%0d exp=1", c); end
            end
            if (bus_write) begin
                checks++;
                if (c < 3 || c > 5 || data_out_sel !== 2'(c - 3))
                    begin errors++; $display("FAIL irq_write c=%0d sel=%0d", c, data_out_sel); end
            end
            if (c == 6) begin
                checks++;
                if (vector_addr !== 16'hFFFE) begin errors++; $display("FAIL irq_vec_lo got=%h exp=FFFE", vector_addr); end
            end
            if (c == 7) begin
                checks++;
                if (vector_addr !== 16'hFFFF) begin errors++; $display("FAIL irq_vec_hi got=%h exp=FFFF", vector_addr); end
            end
            advance();
        end
        checks++;
        if (busy_n != 7) begin errors++; $display("FAIL irq_busy_len got=%0d exp=7", busy_n); end
        checks++;
        if (ack_n != 1) begin errors++; $display("FAIL irq_ack_count got=%0d exp=1", ack_n); end
        $display("test_irq done");
    endtask

    task automatic test_nmi_priority();
        outs_t exp, obs;
        int nmi_n = 0, irq_n = 0;
        nmi_generated = 1'b1; irq_generated = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL nmi_cycle c=%0d got=%h exp=%h", c, obs, exp); end
            if (nmi_acknowledged) nmi_n++;
            if (irq_acknowledged) irq_n++;
            if (c == 6) begin
                checks++;
                if (vector_addr !== 16'hFFFA) begin errors++; $display("FAIL nmi_vec_lo got=%h exp=FFFA", vector_addr); end
            end
            if (c == 7) begin
                checks++;
                if (vector_addr !== 16'hFFFB) begin errors++; $display("FAIL nmi_vec_hi got=%h exp=FFFB", vector_addr); end
            end
            advance();
        end
        checks++;
        if (nmi_n != 1 || irq_n != 0) begin errors++; $display("FAIL nmi_acks nmi=%0d irq=%0d exp 1/0", nmi_n, irq_n); end
        // IRQ was left pending; the next boundary should take it
        irq_n = 0;
        instr_boundary = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL irq_after_nmi c=%0d got=%h exp=%h", c, obs, exp); end
            if (irq_acknowledged) irq_n++;
            advance();
        end
        checks++;
        if (irq_n != 1) begin errors++; $display("FAIL pending_irq_ack got=%0d exp=1", irq_n); end
        $display("test_nmi_priority done");
    endtask

    task automatic test_brk();
        outs_t exp, obs;
        int ack_n = 0;
        brk_start = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL brk_cycle c=%0d got=%h exp=%h", c, obs, exp); end
            if (irq_acknowledged || nmi_acknowledged) ack_n++;
            if (c == 5) begin
                checks++;
                if (push_b_flag !== 1'b1 || set_i_flag !== 1'b1)
                    begin errors++; $display("FAIL brk_push_p b=%b i=%b exp 1/1", push_b_flag, set_i_flag); end
            end
            advance();
        end
        checks++;
        if (ack_n != 0) begin errors++; $display("FAIL brk_no_ack got=%0d exp=0", ack_n); end
        $display("test_brk done");
    endtask

    task automatic test_stall();
        outs_t exp, obs;
        int busy_n = 0, dec_n = 0, wr_n = 0;
        irq_generated = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 13; c++) begin
            ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL stall_cycle c=%0d got=%h exp=%h", c, obs, exp); end
            if (busy) busy_n++;
            if (sp_dec) dec_n++;
            if (bus_write) wr_n++;
            advance();
        end
        ready = 1'b1;
        checks++;
        if (busy_n != 10) begin errors++; $display("FAIL stall_busy_len got=%0d exp=10", busy_n); end
        checks++;
        if (dec_n != 3 || wr_n != 3) begin errors++; $display("FAIL stall_pulses dec=%0d wr=%0d exp 3/3", dec_n, wr_n); end
        $display("test_stall done");
    endtask

    task automatic test_async_reset();
        outs_t exp, obs;
        int busy_n = 0;
        irq_generated = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL arst_pre c=%0d got=%h exp=%h", c, obs, exp); end
            if (c < 3) advance();
        end
        // Now in PUSH_PCH: drop reset between edges
        #2 nrst = 1'b0;
        #1;
        obs = sample(); checks++;
        if (obs !== reset_outs()) begin errors++; $display("FAIL arst_outputs got=%h exp=%h", obs, reset_outs()); end
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        irq_generated = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL arst_post c=%0d got=%h exp=%h", c, obs, exp); end
            if (busy) busy_n++;
            advance();
        end
        checks++;
        if (busy_n != 7) begin errors++; $display("FAIL arst_clean_seq busy=%0d exp=7", busy_n); end
        $display("test_async_reset done");
    endtask

    task automatic test_nmi_mid_sequence();
        outs_t exp, obs;
        logic [15:0] vlo1 = 16'h0, vlo2 = 16'h0;
        int nvlo = 0, nmi_pos = -1, irq_n = 0;
        irq_generated = 1'b1; instr_boundary = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c == 2) nmi_generated = 1'b1;
            if (c == 8) instr_boundary = 1'b1;
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL mid_nmi c=%0d got=%h exp=%h", c, obs, exp); end
            if (load_pcl) begin
                if (nvlo == 0) vlo1 = vector_addr; else vlo2 = vector_addr;
                nvlo++;
            end
            if (nmi_acknowledged && nmi_pos < 0) nmi_pos = c;
            if (irq_acknowledged) irq_n++;
            advance();
        end
        checks++;
        if (irq_n != 1) begin errors++; $display("FAIL mid_irq_ack got=%0d exp=1", irq_n); end
`ifdef NMI_HIJACK_EN
        checks++;
        if (vlo1 !== NMI_V || nmi_pos != 3)
            begin errors++; $display("FAIL hijack vec=%h ackpos=%0d exp FFFA/3", vlo1, nmi_pos); end
`else
        checks++;
        if (vlo1 !== IRQ_V || vlo2 !== NMI_V || nmi_pos != 9)
            begin errors++; $display("FAIL no_hijack vec1=%h vec2=%h ackpos=%0d exp FFFE/FFFA/9", vlo1, vlo2, nmi_pos); end
`endif
        $display("test_nmi_mid_sequence done");
    endtask

    task automatic test_random();
        outs_t exp, obs;
        int bad = 0;
        for (int c = 0; c < 800; c++) begin
            ready          = ($urandom_range(0, 9) != 0);
            instr_boundary = ($urandom_range(0, 3) == 0);
            brk_start      = instr_boundary && ($urandom_range(0, 3) == 0);
            if (!irq_generated && $urandom_range(0, 7) == 0)  irq_generated = 1'b1;
            if (!nmi_generated && $urandom_range(0, 15) == 0) nmi_generated = 1'b1;
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin
                errors++; bad++;
                if (bad <= 10) $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp);
            end
            advance();
        end
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp = model_out(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL random_drain c=%0d got=%h exp=%h", c, obs, exp); end
            advance();
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_irq();
        test_nmi_priority();
        test_brk();
        test_stall();
        test_async_reset();
        test_nmi_mid_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
